// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, 80 MHz timing defaults and init-sequencer state type.
// Imported by sdram_init_seq and by the SDRAM read/write controller.
package sdram_pkg;

  localparam int DEF_W_SDRAM_BANKSEL = 2;
  localparam int DEF_W_SDRAM_ADDR    = 13;
  localparam int DEF_T_POWERUP_CYC   = 8000;
  localparam int DEF_T_RP_CYC        = 2;
  localparam int DEF_T_RFC_CYC       = 6;
  localparam int DEF_T_MRD_CYC       = 2;
  localparam int DEF_T_REFI_CYC      = 624;
  localparam int DEF_MAX_PENDING     = 8;
  localparam logic [12:0] DEF_MODE_REG = 13'h023;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_INHIBIT      = 4'b1111;
  localparam logic [3:0] CMD_NOP          = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
  localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;
  localparam logic [3:0] CMD_LOAD_MODE    = 4'b0000;

  localparam int A_PRECHARGE_ALL_BIT = 10;

  typedef enum logic [3:0] {
    ST_POWERUP,
    ST_PRECHARGE,
    ST_WAIT_RP,
    ST_REFRESH,
    ST_WAIT_RFC,
    ST_LOAD_MODE,
    ST_WAIT_MRD,
    ST_IDLE,
    ST_R_PRECHARGE,
    ST_R_WAIT_RP,
    ST_R_REFRESH,
    ST_R_WAIT_RFC
  } init_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sdram_init_seq.sv
// SDRAM power-up initialisation and auto-refresh scheduler; owns the command pins
// through init and during each granted refresh slot.
//
// state          | meaning
// ---------------+-------------------------------------------------------------
// POWERUP        | clke high, INHIBIT, waiting out the power-up interval
// PRECHARGE      | PRECHARGE ALL issued (init)
// WAIT_RP        | NOP until tRP elapses
// REFRESH        | AUTO REFRESH issued (init, first or second per ref2 flag)
// WAIT_RFC       | NOP until tRFC elapses
// LOAD_MODE      | LOAD MODE issued with MODE_REG
// WAIT_MRD       | NOP until tMRD elapses
// IDLE           | bus released to controller, waiting for refresh grant
// R_PRECHARGE    | PRECHARGE ALL issued (periodic refresh)
// R_WAIT_RP      | NOP until tRP elapses
// R_REFRESH      | AUTO REFRESH issued, one pending refresh retired
// R_WAIT_RFC     | NOP until tRFC elapses, then bus released
module sdram_init_seq
  import sdram_pkg::*;
#(
  parameter int W_SDRAM_BANKSEL = DEF_W_SDRAM_BANKSEL,
  parameter int W_SDRAM_ADDR    = DEF_W_SDRAM_ADDR,
  parameter int T_POWERUP_CYC   = DEF_T_POWERUP_CYC,
  parameter int T_RP_CYC        = DEF_T_RP_CYC,
  parameter int T_RFC_CYC       = DEF_T_RFC_CYC,
  parameter int T_MRD_CYC       = DEF_T_MRD_CYC,
  parameter int T_REFI_CYC      = DEF_T_REFI_CYC,
  parameter logic [W_SDRAM_ADDR-1:0] MODE_REG = W_SDRAM_ADDR'(DEF_MODE_REG),
  parameter int MAX_PENDING     = DEF_MAX_PENDING
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       sdram_clke,
  output logic                       sdram_cs_n,
  output logic                       sdram_ras_n,
  output logic                       sdram_cas_n,
  output logic                       sdram_we_n,
  output logic [W_SDRAM_ADDR-1:0]    sdram_a,
  output logic [W_SDRAM_BANKSEL-1:0] sdram_ba,
  output logic                       bus_own,
  output logic                       init_done,
  output logic                       refresh_req,
  input  logic                       refresh_ack
);

  localparam int W_WAIT = $clog2(max_int(max_int(T_POWERUP_CYC, T_RFC_CYC),
                                         max_int(T_RP_CYC, T_MRD_CYC)) + 1);
  localparam int W_REFI = $clog2(T_REFI_CYC + 1);
  localparam int W_PEND = $clog2(MAX_PENDING + 1);

  localparam logic [W_WAIT-1:0] PU_LOAD   = W_WAIT'(T_POWERUP_CYC - 1);
  localparam logic [W_WAIT-1:0] RP_LOAD   = W_WAIT'(T_RP_CYC - 1);
  localparam logic [W_WAIT-1:0] RFC_LOAD  = W_WAIT'(T_RFC_CYC - 1);
  localparam logic [W_WAIT-1:0] MRD_LOAD  = W_WAIT'(T_MRD_CYC - 1);
  localparam logic [W_REFI-1:0] REFI_LOAD = W_REFI'(T_REFI_CYC - 1);
  localparam logic [W_PEND-1:0] PEND_MAX  = W_PEND'(MAX_PENDING);

  init_state_e                state_q, state_d;
  logic [W_WAIT-1:0]          wait_q, wait_d;
  logic                       ref2_q, ref2_d;
  logic [W_REFI-1:0]          refi_q, refi_d;
  logic [W_PEND-1:0]          pend_q, pend_d;
  logic                       pend_dec;
  logic                       tick;

  logic                       clke_q;
  logic [3:0]                 cmd_q, cmd_d;
  logic [W_SDRAM_ADDR-1:0]    a_q, a_d;
  logic [W_SDRAM_BANKSEL-1:0] ba_q, ba_d;
  logic                       bus_own_q, bus_own_d;
  logic                       init_done_q, init_done_d;
  logic                       req_q, req_d;

  // Command states double as the first cycle of their wait, so each load of T-1
  // lands the next command exactly T cycles later.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    ref2_d   = ref2_q;
    pend_dec = 1'b0;
    case (state_q)
      ST_POWERUP: begin
        if (clke_q) begin
          if (wait_q == '0) begin
            state_d = ST_PRECHARGE;
            wait_d  = RP_LOAD;
          end else begin
            wait_d = wait_q - 1'b1;
          end
        end
      end
      ST_PRECHARGE, ST_WAIT_RP: begin
        if (wait_q == '0) begin
          state_d = ST_REFRESH;
          wait_d  = RFC_LOAD;
        end else begin
          state_d = ST_WAIT_RP;
          wait_d  = wait_q - 1'b1;
        end
      end
      ST_REFRESH, ST_WAIT_RFC: begin
        if (wait_q == '0) begin
          if (ref2_q) begin
            state_d = ST_LOAD_MODE;
            wait_d  = MRD_LOAD;
          end else begin
            state_d = ST_REFRESH;
            wait_d  = RFC_LOAD;
            ref2_d  = 1'b1;
          end
        end else begin
          state_d = ST_WAIT_RFC;
          wait_d  = wait_q - 1'b1;
        end
      end
      ST_LOAD_MODE, ST_WAIT_MRD: begin
        if (wait_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_MRD;
          wait_d  = wait_q - 1'b1;
        end
      end
      ST_IDLE: begin
        if (req_q && refresh_ack) begin
          state_d = ST_R_PRECHARGE;
          wait_d  = RP_LOAD;
        end
      end
      ST_R_PRECHARGE, ST_R_WAIT_RP: begin
        if (wait_q == '0) begin
          state_d  = ST_R_REFRESH;
          wait_d   = RFC_LOAD;
          pend_dec = 1'b1;
        end else begin
          state_d = ST_R_WAIT_RP;
          wait_d  = wait_q - 1'b1;
        end
      end
      ST_R_REFRESH, ST_R_WAIT_RFC: begin
        if (wait_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_R_WAIT_RFC;
          wait_d  = wait_q - 1'b1;
        end
      end
      default: state_d = ST_POWERUP;
    endcase
  end

  always_comb begin
    cmd_d       = CMD_NOP;
    a_d         = '0;
    ba_d        = '0;
    bus_own_d   = (state_d != ST_IDLE);
    init_done_d = init_done_q | (state_d == ST_IDLE);
    case (state_d)
      ST_POWERUP: cmd_d = CMD_INHIBIT;
      ST_PRECHARGE, ST_R_PRECHARGE: begin
        cmd_d                      = CMD_PRECHARGE;
        a_d[A_PRECHARGE_ALL_BIT]   = 1'b1;
      end
      ST_REFRESH, ST_R_REFRESH: cmd_d = CMD_AUTO_REFRESH;
      ST_LOAD_MODE: begin
        cmd_d = CMD_LOAD_MODE;
        a_d   = MODE_REG;
      end
      default: cmd_d = CMD_NOP;
    endcase
  end

  // A tick and a retire in the same cycle cancel out, even at saturation.
  always_comb begin
    refi_d = refi_q;
    tick   = 1'b0;
    if (init_done_q) begin
      if (refi_q == '0) begin
        tick   = 1'b1;
        refi_d = REFI_LOAD;
      end else begin
        refi_d = refi_q - 1'b1;
      end
    end
    pend_d = pend_q;
    case ({tick, pend_dec})
      2'b10:   if (pend_q != PEND_MAX) pend_d = pend_q + 1'b1;
      2'b01:   pend_d = pend_q - 1'b1;
      default: pend_d = pend_q;
    endcase
    req_d = (pend_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_POWERUP;
      wait_q      <= PU_LOAD;
      ref2_q      <= 1'b0;
      refi_q      <= REFI_LOAD;
      pend_q      <= '0;
      clke_q      <= 1'b0;
      cmd_q       <= CMD_INHIBIT;
      a_q         <= '0;
      ba_q        <= '0;
      bus_own_q   <= 1'b1;
      init_done_q <= 1'b0;
      req_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      ref2_q      <= ref2_d;
      refi_q      <= refi_d;
      pend_q      <= pend_d;
      clke_q      <= 1'b1;
      cmd_q       <= cmd_d;
      a_q         <= a_d;
      ba_q        <= ba_d;
      bus_own_q   <= bus_own_d;
      init_done_q <= init_done_d;
      req_q       <= req_d;
    end
  end

  assign sdram_clke = clke_q;
  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_q;
  assign sdram_a     = a_q;
  assign sdram_ba    = ba_q;
  assign bus_own     = bus_own_q;
  assign init_done   = init_done_q;
  assign refresh_req = req_q;

endmodule

// File: tb/tb_sdram_init_seq.sv
// Bench for sdram_init_seq: a cycle-indexed schedule model predicts every output
// from reset release, refresh ticks and accepted grants.
module tb_sdram_init_seq;

  localparam int P    = 20;
  localparam int RP   = 2;
  localparam int RFC  = 6;
  localparam int MRD  = 2;
  localparam int REFI = 50;
  localparam int MAXP = 8;
  localparam logic [12:0] MODE = 13'h023;
  localparam int D = P + 1 + RP + 2 * RFC + MRD;

  localparam logic [3:0] C_INH = 4'b1111;
  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_LMR = 4'b0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        refresh_ack = 1'b0;
  logic        sdram_clke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [12:0] sdram_a;
  logic [1:0]  sdram_ba;
  logic        bus_own, init_done, refresh_req;

  sdram_init_seq #(
    .W_SDRAM_BANKSEL(2), .W_SDRAM_ADDR(13), .T_POWERUP_CYC(P), .T_RP_CYC(RP),
    .T_RFC_CYC(RFC), .T_MRD_CYC(MRD), .T_REFI_CYC(REFI), .MODE_REG(MODE),
    .MAX_PENDING(MAXP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sdram_clke(sdram_clke), .sdram_cs_n(sdram_cs_n),
    .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .sdram_a(sdram_a), .sdram_ba(sdram_ba), .bus_own(bus_own), .init_done(init_done),
    .refresh_req(refresh_req), .refresh_ack(refresh_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_cyc = 0;
  int m_pending = 0;
  int m_win = -1;
  logic [22:0] exp_vec, exp_mask;

  function automatic bit in_win(input int k);
    return (m_win >= 0) && (k >= m_win) && (k < m_win + RP + RFC);
  endfunction

  function automatic bit m_idle(input int k);
    return (k >= D) && !in_win(k);
  endfunction

  function automatic logic [22:0] obs_vec();
    return {sdram_clke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
            bus_own, init_done, refresh_req, sdram_a, sdram_ba};
  endfunction

  task automatic model_outputs();
    logic clke, own, done, req, chk_ab;
    logic [3:0] cmd;
    logic [12:0] a;
    clke = 1'b1; own = 1'b1; done = 1'b0; req = (m_pending != 0);
    cmd = C_NOP; a = '0; chk_ab = 1'b0;
    if (m_cyc == 0) begin
      clke = 1'b0; cmd = C_INH; chk_ab = 1'b1;
    end else if (m_cyc <= P) begin
      cmd = C_INH;
    end else if (m_cyc < D) begin
      if (m_cyc == P + 1) begin
        cmd = C_PRE; a = 13'h400; chk_ab = 1'b1;
      end else if (m_cyc == P + 1 + RP || m_cyc == P + 1 + RP + RFC) begin
        cmd = C_REF;
      end else if (m_cyc == P + 1 + RP + 2 * RFC) begin
        cmd = C_LMR; a = MODE; chk_ab = 1'b1;
      end
    end else begin
      done = 1'b1;
      own  = in_win(m_cyc);
      if (own && m_cyc == m_win) begin
        cmd = C_PRE; a = 13'h400; chk_ab = 1'b1;
      end else if (own && m_cyc == m_win + RP) begin
        cmd = C_REF;
      end
    end
    exp_mask = chk_ab ? {23{1'b1}} : {8'hFF, 15'h0};
    exp_vec  = {clke, cmd, own, done, req, a, 2'b00} & exp_mask;
  endtask

  task automatic model_reset();
    m_cyc = 0; m_pending = 0; m_win = -1;
    model_outputs();
  endtask

  // Drives ack for the current cycle, advances one clock and updates the model.
  task automatic step(input logic ack);
    logic acc, inc, dec;
    refresh_ack = ack;
    acc = ack && m_idle(m_cyc) && (m_pending != 0);
    @(posedge clk); #1;
    m_cyc++;
    if (acc) m_win = m_cyc;
    inc = (m_cyc > D) && (((m_cyc - D) % REFI) == 0);
    dec = (m_win >= 0) && (m_cyc == m_win + RP);
    if (inc && !dec) m_pending = (m_pending < MAXP) ? m_pending + 1 : m_pending;
    else if (dec && !inc) m_pending--;
    model_outputs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; refresh_ack = 1'b0;
    model_reset();
    repeat (3) begin
      @(posedge clk); #1;
      if ((obs_vec() & exp_mask) !== exp_vec) begin
        errors++;
        $display("FAIL reset got=%b want=%b", obs_vec() & exp_mask, exp_vec);
      end
      checks++;
    end
  endtask

  task automatic test_init();
    rst_n = 1'b1;
    for (int k = 0; k < D + 3; k++) begin
      step(1'b0);
      if ((obs_vec() & exp_mask) !== exp_vec) begin
        errors++;
        $display("FAIL init cyc=%0d got=%b want=%b", m_cyc, obs_vec() & exp_mask, exp_vec);
      end
      checks++;
    end
  endtask

  task automatic test_saturation();
    int cmds = 0;
    for (int k = 0; k < 1000; k++) begin
      step(1'b0);
      if ({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} != C_NOP) cmds++;
      if ((obs_vec() & exp_mask) !== exp_vec) begin
        errors++;
        $display("FAIL saturate cyc=%0d got=%b want=%b", m_cyc, obs_vec() & exp_mask, exp_vec);
      end
      checks++;
    end
    if (cmds !== 0 || refresh_req !== 1'b1) begin
      errors++;
      $display("FAIL saturate_idle cmds=%0d req=%b want cmds=0 req=1", cmds, refresh_req);
    end
    checks++;
  endtask

  task automatic test_single_ack();
    int own_cnt = 0;
    step(1'b1);
    for (int k = 0; k < 13; k++) begin
      if (k > 0) step(1'b0);
      if (bus_own === 1'b1) own_cnt++;
      if ((obs_vec() & exp_mask) !== exp_vec) begin
        errors++;
        $display("FAIL single_ack cyc=%0d got=%b want=%b", m_cyc, obs_vec() & exp_mask, exp_vec);
      end
      checks++;
    end
    if (own_cnt !== RP + RFC) begin
      errors++;
      $display("FAIL single_ack_own got=%0d want=%0d", own_cnt, RP + RFC);
    end
    checks++;
  endtask

  // Drains to 3 pending, grants so R_REFRESH entry meets a tick, then drains to 0;
  // the drain timing exposes the pending count left by the coincident cycle.
  task automatic test_tick_coincident();
    bit hit = 1'b0, fin = 1'b0;
    logic ack;
    for (int n = 0; n < 3000 && !fin; n++) begin
      ack = 1'b0;
      if (m_idle(m_cyc) && m_pending != 0) begin
        if (hit || m_pending > 3) ack = 1'b1;
        else if (m_pending == 3 && (((m_cyc + 1 + RP - D) % REFI) == 0)) begin
          ack = 1'b1; hit = 1'b1;
        end
      end
      step(ack);
      if ((obs_vec() & exp_mask) !== exp_vec) begin
        errors++;
        $display("FAIL tick_coincident cyc=%0d got=%b want=%b", m_cyc, obs_vec() & exp_mask, exp_vec);
      end
      checks++;
      if (hit && m_pending == 0 && m_idle(m_cyc)) fin = 1'b1;
    end
    if (fin !== 1'b1) begin
      errors++;
      $display("FAIL tick_coincident_timeout got=%b want=1", fin);
    end
    checks++;
  endtask

  task automatic test_ignored_ack();
    bit found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(1'b1);
      if ((obs_vec() & exp_mask) !== exp_vec) begin
        errors++;
        $display("FAIL ack_no_req cyc=%0d got=%b want=%b", m_cyc, obs_vec() & exp_mask, exp_vec);
      end
      checks++;
    end
    for (int k = 0; k < 3 * REFI && !found; k++) begin
      if (m_idle(m_cyc) && m_pending != 0) found = 1'b1;
      else step(1'b0);
    end
    for (int k = 0; k < RP + RFC + 6; k++) begin
      step(1'b1);
      if ((obs_vec() & exp_mask) !== exp_vec) begin
        errors++;
        $display("FAIL ack_held cyc=%0d got=%b want=%b", m_cyc, obs_vec() & exp_mask, exp_vec);
      end
      checks++;
    end
    if (found !== 1'b1) begin
      errors++;
      $display("FAIL ack_held_timeout got=%b want=1", found);
    end
    checks++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 800; k++) begin
      step($urandom_range(0, 3) == 0);
      if ((obs_vec() & exp_mask) !== exp_vec) begin
        errors++;
        $display("FAIL random cyc=%0d got=%b want=%b", m_cyc, obs_vec() & exp_mask, exp_vec);
      end
      checks++;
    end
  endtask

  task automatic test_reset_midway();
    #2 rst_n = 1'b0; refresh_ack = 1'b0;
    #1 model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    while (m_cyc < P + 1 + RP + 3) step(1'(($urandom_range(0, 1))));
    #2 rst_n = 1'b0; refresh_ack = 1'b0;
    #1 model_reset();
    if ((obs_vec() & exp_mask) !== exp_vec) begin
      errors++;
      $display("FAIL midway_reset got=%b want=%b", obs_vec() & exp_mask, exp_vec);
    end
    checks++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < D + REFI + 5; k++) begin
      step(1'b0);
      if ((obs_vec() & exp_mask) !== exp_vec) begin
        errors++;
        $display("FAIL rerun cyc=%0d got=%b want=%b", m_cyc, obs_vec() & exp_mask, exp_vec);
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_saturation();
    test_single_ack();
    test_tick_coincident();
    test_ignored_ack();
    test_random();
    test_reset_midway();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
